// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard/control bundle between the pipeline datapath and pipe_hazard_ctrl.
// master = datapath side (drives hazard indications), slave = the controller.
interface pipe_hazard_ctrl_if;
    logic       load_use_bubble;
    logic       jump_flush;
    logic       branch_taken;
    logic       exception;
    logic       irq_req;
    logic       kernel_mode;
    logic       id_valid;
    logic       ex_branch;
    logic       pc_we;
    logic       if_id_we;
    logic       if_id_flush;
    logic       id_ex_flush;
    logic       irq_to_ctrl;
    logic       irq_ack;
    logic [1:0] irq_state;

    // All signals are single-cycle levels sampled on the rising clk edge; no handshake stalls.
    modport master (
        output load_use_bubble, jump_flush, branch_taken, exception,
               irq_req, kernel_mode, id_valid, ex_branch,
        input  pc_we, if_id_we, if_id_flush, id_ex_flush,
               irq_to_ctrl, irq_ack, irq_state
    );

    modport slave (
        input  load_use_bubble, jump_flush, branch_taken, exception,
               irq_req, kernel_mode, id_valid, ex_branch,
        output pc_we, if_id_we, if_id_flush, id_ex_flush,
               irq_to_ctrl, irq_ack, irq_state
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush priority logic and IRQ entry FSM for the 5-stage pipeline.
// Optional saturating stall/flush counters are enabled with `define PIPE_HAZARD_STATS_EN.
module pipe_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset_b,
    pipe_hazard_ctrl_if.slave hz
`ifdef PIPE_HAZARD_STATS_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    if (CNT_W < 1) begin : g_cnt_w_check
        $error("CNT_W must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        ENTERED = 2'd2,
        HANDLER = 2'd3
    } irq_state_t;

    irq_state_t state_q, state_d;
    logic       irq_take;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q    <= IDLE;
            hz.irq_ack <= 1'b0;
        end else begin
            state_q    <= state_d;
            hz.irq_ack <= irq_take;
        end
    end

    // The IRQ may only replace an ID instruction that is real and will not be killed or held.
    always_comb begin
        state_d  = state_q;
        irq_take = 1'b0;
        case (state_q)
            IDLE: begin
                if (hz.irq_req && !hz.kernel_mode) state_d = PENDING;
            end
            PENDING: begin
                irq_take = hz.id_valid && !hz.ex_branch && !hz.branch_taken &&
                           !hz.load_use_bubble && !hz.exception && !hz.kernel_mode;
                if (irq_take)         state_d = ENTERED;
                else if (!hz.irq_req) state_d = IDLE;
            end
            ENTERED: begin
                if (hz.kernel_mode) state_d = HANDLER;
            end
            HANDLER: begin
                if (!hz.kernel_mode) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign hz.irq_to_ctrl = irq_take;
    assign hz.irq_state   = state_q;

    // Fixed priority: taken branch > trap entry > load-use stall > jump.
    always_comb begin
        hz.pc_we       = 1'b1;
        hz.if_id_we    = 1'b1;
        hz.if_id_flush = 1'b0;
        hz.id_ex_flush = 1'b0;
        if (hz.branch_taken) begin
            hz.if_id_flush = 1'b1;
            hz.id_ex_flush = 1'b1;
        end else if (hz.exception || irq_take) begin
            hz.if_id_flush = 1'b1;
        end else if (hz.load_use_bubble) begin
            hz.pc_we       = 1'b0;
            hz.if_id_we    = 1'b0;
            hz.id_ex_flush = 1'b1;
        end else if (hz.jump_flush) begin
            hz.if_id_flush = 1'b1;
        end
    end

`ifdef PIPE_HAZARD_STATS_EN
    logic stall_hit;
    // irq_take already excludes load-use, so only branch/exception can pre-empt the stall.
    assign stall_hit = hz.load_use_bubble && !hz.branch_taken && !hz.exception;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_hit && (stall_cnt != '1))      stall_cnt <= stall_cnt + CNT_W'(1);
            if (hz.if_id_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush and interrupt-entry controller for the 5-stage pipeline. It combines the per-stage hazard indications into one consistent set of PC/IF_ID write enables and per-register flushes, with a fixed priority among them. It also runs the IRQ entry state machine. That machine decides the cycle in which the ID-stage instruction is replaced by the interrupt pseudo-instruction, and it drives the `IRQ` input of the control unit.

## Interface
Parameters:
- `CNT_W`, default 16: width of the statistics counters (only present with `PIPE_HAZARD_STATS_EN`).

Ports:
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `reset_b`  in  1  asynchronous, active-low reset.
- `load_use_bubble`  in  1  load-use hazard on the ID instruction (ID_EX is a load; its Rt matches ID Rs/Rt).
- `jump_flush`  in  1  ID holds j/jal/jr/jalr.
- `branch_taken`  in  1  EX resolved a taken branch.
- `exception`  in  1  ID opcode undefined. Decoded independently of `irq_to_ctrl`.
- `irq_req`  in  1  level interrupt request; the source drops it after `irq_ack`.
- `kernel_mode`  in  1  PC[31] of the ID-stage instruction.
- `id_valid`  in  1  IF_ID holds a real instruction, not a flushed slot.
- `ex_branch`  in  1  ID_EX holds an unresolved branch.
- `pc_we`  out  1  PC register write enable.
- `if_id_we`  out  1  IF_ID write enable.
- `if_id_flush`  out  1  load zero into IF_ID at next edge.
- `id_ex_flush`  out  1  load zero into ID_EX at next edge.
- `irq_to_ctrl`  out  1  to control unit `IRQ`: replace the ID instruction with interrupt entry.
- `irq_ack`  out  1  registered one-cycle pulse; the IRQ was taken.
- `irq_state`  out  2  FSM state, for debug.
- `stall_cnt`, `flush_cnt`  out  `CNT_W` each  (`PIPE_HAZARD_STATS_EN` only).

## Operation
Flush/enable outputs are combinational. The first matching rule wins:
1. `branch_taken`: `pc_we`=1, `if_id_flush`=1, `id_ex_flush`=1, `if_id_we`=1. The younger ID instruction is killed, including any exception, jump or IRQ on it.
2. `exception` or IRQ taken this cycle: `pc_we`=1, `if_id_flush`=1, `id_ex_flush`=0. The trap pseudo-instruction proceeds to EX to save the return PC.
3. `load_use_bubble`: `pc_we`=0, `if_id_we`=0, `id_ex_flush`=1. Rule 3 beats `jump_flush`, because jr must see the loaded Rs.
4. `jump_flush`: `pc_we`=1, `if_id_flush`=1.
5. No rule matches: `pc_we`=`if_id_we`=1, both flushes 0.

IRQ FSM (`irq_state` encoding):
- IDLE=0: go to PENDING when `irq_req` && !`kernel_mode`.
- PENDING=1: `irq_to_ctrl` = `id_valid` && !`ex_branch` && !`branch_taken` && !`load_use_bubble` && !`exception` && !`kernel_mode`.
  - If `irq_to_ctrl`=1: go to ENTERED and pulse `irq_ack` next cycle.
  - Else if !`irq_req`: return to IDLE (request withdrawn).
  - Otherwise stay.
- ENTERED=2: go to HANDLER when `kernel_mode`=1.
- HANDLER=3: go to IDLE when `kernel_mode`=0 (handler returned via jr $26). `irq_req` seen in that same cycle is handled through IDLE on the following cycle.
- `irq_to_ctrl`=0 in every state except PENDING.
- An exception while PENDING is taken first. The IRQ stays PENDING, and because `kernel_mode`=1 blocks it, it waits until user mode resumes.

## Timing
- Reset values:
  - `irq_state`=IDLE, `irq_ack`=0, counters 0.
  - Combinational outputs with all inputs low: `pc_we`=`if_id_we`=1, flushes 0, `irq_to_ctrl`=0.
- Reset is honoured mid-handler: the FSM returns to IDLE immediately.
- Latency:
  - Hazard to enables: 0 cycles (same-cycle combinational).
  - IRQ taken to `irq_ack`: 1 cycle.
  - `irq_req` rising (user mode, no blockers) to `irq_to_ctrl`: 1 cycle (IDLE→PENDING edge).
- No combinational path from `irq_to_ctrl` back into any input.

## Configuration
- `PIPE_HAZARD_STATS_EN` defined:
  - `stall_cnt` increments on each cycle with rule 3 active.
  - `flush_cnt` increments on each cycle with `if_id_flush`=1.
  - Both saturate at all-ones, reset to 0.
- `PIPE_HAZARD_STATS_EN` undefined: counters and their ports are absent. All other behaviour is identical.

## Test plan
- `load_use_bubble`=1 with `jump_flush`=1, one cycle → `pc_we`=0, `if_id_we`=0, `id_ex_flush`=1, `if_id_flush`=0.
- `branch_taken`=1 with `exception`=1 and `jump_flush`=1 → `if_id_flush`=`id_ex_flush`=1, `pc_we`=1; exception ignored.
- `irq_req`=1, user mode, `id_valid`=1, no hazards:
  - `irq_state` goes 0→1 → `irq_to_ctrl`=1 in the PENDING cycle.
  - `irq_ack`=1 exactly one cycle later; state=2.
  - `kernel_mode`=1 → 3; `kernel_mode`=0 → 0.
- PENDING with `ex_branch`=1 for 3 cycles, then 0 → `irq_to_ctrl` held 0 for 3 cycles, 1 on the 4th.
- PENDING, `irq_req` dropped before it can be taken → return to IDLE; no `irq_ack`.
- With `PIPE_HAZARD_STATS_EN`, `CNT_W`=4: 20 bubble cycles → `stall_cnt`=15 (saturated); reset mid-run → 0.
